// File: rtl/gray_pkg.sv
// Shared types for the Gray-code decoder: tracking FSM states and step-direction codes.
package gray_pkg;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    DIR_HOLD = 2'b00,
    DIR_UP   = 2'b01,
    DIR_DOWN = 2'b10,
    DIR_NONE = 2'b11
  } dir_t;

endpackage

// File: rtl/gray2bin.sv
// Combinational reflected-Gray to binary converter.
// Ports: gray - Gray-coded input (N bits); bin - binary equivalent (N bits).
module gray2bin #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] gray,
  output logic [N-1:0] bin
);

  // Binary bit i is the XOR of all Gray bits from i up to the MSB.
  always_comb begin
    bin = '0;
    for (int unsigned i = 0; i < N; i++) begin
      bin[i] = ^(gray >> i);
    end
  end

endmodule

// File: rtl/gray_dec.sv
// Two-stage Gray decoder with step-direction tracking and a saturating step-error counter.
// Ports:
//   clk, rstn          - clock, asynchronous active-low reset
//   in_valid, gray_in  - input sample strobe and Gray-coded sample
//   clr                - synchronous clear of tracking state, pipeline and error count
//   out_valid, bin_out - decoded result strobe and binary value
//   dir                - step vs previous sample: 00 hold, 01 up, 10 down, 11 invalid/none
//   step_err           - one-cycle pulse on a multi-bit Gray jump
//   err_cnt            - saturating count of step_err pulses
//   locked             - a reference sample exists
module gray_dec
  import gray_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  input  logic [N-1:0]     gray_in,
  input  logic             clr,
  output logic             out_valid,
  output logic [N-1:0]     bin_out,
  output logic [1:0]       dir,
  output logic             step_err,
  output logic [CNT_W-1:0] err_cnt,
  output logic             locked
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t       state;
  logic         s1_valid;
  logic [N-1:0] s1_gray;
  logic [N-1:0] s1_bin;
  logic [N-1:0] ref_gray;
  logic [N-1:0] diff;
  logic         dist_zero;
  logic         dist_gt1;
  logic         is_up;
  logic         is_down;

  gray2bin #(.N(N)) u_gray2bin (
    .gray (s1_gray),
    .bin  (s1_bin)
  );

  // Hamming classification against the reference; bin_out always holds the reference's binary value.
  always_comb begin
    diff      = s1_gray ^ ref_gray;
    dist_zero = (diff == '0);
    dist_gt1  = ((diff & (diff - N'(1))) != '0);
    is_up     = (s1_bin == N'(bin_out + N'(1)));
    is_down   = (s1_bin == N'(bin_out - N'(1)));
  end

  assign locked = (state == LOCKED);

  // Pipeline, tracking FSM and error counter; clr wins over an incoming sample.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= UNLOCKED;
      s1_valid  <= 1'b0;
      s1_gray   <= '0;
      ref_gray  <= '0;
      out_valid <= 1'b0;
      bin_out   <= '0;
      dir       <= DIR_NONE;
      step_err  <= 1'b0;
      err_cnt   <= '0;
    end else if (clr) begin
      state     <= UNLOCKED;
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
      step_err  <= 1'b0;
      err_cnt   <= '0;
    end else begin
      s1_valid  <= in_valid;
      s1_gray   <= gray_in;
      out_valid <= s1_valid;
      step_err  <= 1'b0;
      if (s1_valid) begin
        bin_out  <= s1_bin;
        ref_gray <= s1_gray;
        state    <= LOCKED;
        if (state == UNLOCKED) begin
          dir <= DIR_NONE;
        end else if (dist_zero) begin
          dir <= DIR_HOLD;
        end else if (dist_gt1) begin
          dir      <= DIR_NONE;
          step_err <= 1'b1;
          if (err_cnt != CNT_MAX) begin
            err_cnt <= err_cnt + CNT_W'(1);
          end
        end else if (is_up) begin
          dir <= DIR_UP;
        end else if (is_down) begin
          dir <= DIR_DOWN;
        end else begin
          // Single-bit Gray change that is not an adjacent code: no direction, not a jump.
          dir <= DIR_NONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_gray_dec.sv
// Scoreboard bench for gray_dec: default instance plus a CNT_W=2 instance sharing stimulus.
module tb_gray_dec;

  localparam int unsigned N     = 4;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned SAT_W = 2;

  logic             clk      = 1'b0;
  logic             rstn     = 1'b0;
  logic             in_valid = 1'b0;
  logic             clr      = 1'b0;
  logic [N-1:0]     gray_in  = '0;

  logic             out_valid, step_err, locked;
  logic [N-1:0]     bin_out;
  logic [1:0]       dir;
  logic [CNT_W-1:0] err_cnt;

  logic             s_out_valid, s_step_err, s_locked;
  logic [N-1:0]     s_bin_out;
  logic [1:0]       s_dir;
  logic [SAT_W-1:0] s_err_cnt;

  gray_dec #(.N(N), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .gray_in(gray_in), .clr(clr),
    .out_valid(out_valid), .bin_out(bin_out), .dir(dir), .step_err(step_err),
    .err_cnt(err_cnt), .locked(locked)
  );

  gray_dec #(.N(N), .CNT_W(SAT_W)) dut_sat (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .gray_in(gray_in), .clr(clr),
    .out_valid(s_out_valid), .bin_out(s_bin_out), .dir(s_dir), .step_err(s_step_err),
    .err_cnt(s_err_cnt), .locked(s_locked)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       vld;
    logic [3:0] bin;
    logic [1:0] dir;
    logic       step;
    logic [7:0] cnt8;
    logic [1:0] cnt2;
    logic       lock;
  } exp_t;

  exp_t q[$];
  exp_t last_obs;
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  logic       m_lock;
  logic [3:0] m_ref;
  logic [3:0] m_bin;
  logic [1:0] m_dir;
  logic [7:0] m_cnt8;
  logic [1:0] m_cnt2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] g2b(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic exp_t idle_entry();
    exp_t e;
    e.vld  = 1'b0;
    e.bin  = m_bin;
    e.dir  = m_dir;
    e.step = 1'b0;
    e.cnt8 = m_cnt8;
    e.cnt2 = m_cnt2;
    e.lock = m_lock;
    return e;
  endfunction

  task automatic compare(input exp_t e);
    check("out_valid",     32'(out_valid),   32'(e.vld));
    check("bin_out",       32'(bin_out),     32'(e.bin));
    check("dir",           32'(dir),         32'(e.dir));
    check("step_err",      32'(step_err),    32'(e.step));
    check("err_cnt",       32'(err_cnt),     32'(e.cnt8));
    check("locked",        32'(locked),      32'(e.lock));
    check("sat_out_valid", 32'(s_out_valid), 32'(e.vld));
    check("sat_bin_out",   32'(s_bin_out),   32'(e.bin));
    check("sat_dir",       32'(s_dir),       32'(e.dir));
    check("sat_step_err",  32'(s_step_err),  32'(e.step));
    check("sat_err_cnt",   32'(s_err_cnt),   32'(e.cnt2));
    check("sat_locked",    32'(s_locked),    32'(e.lock));
    last_obs = e;
  endtask

  // One cycle: check what the DUT shows now, then drive the next input and predict it.
  task automatic cycle(input logic v, input logic [3:0] g, input logic c);
    exp_t       e;
    logic [3:0] b, up, dn;
    int         d;
    @(negedge clk);
    if (q.size() >= 2) compare(q.pop_front());
    rstn     = 1'b1;
    in_valid = v;
    gray_in  = g;
    clr      = c;
    if (c) begin
      // In-flight sample is dropped, so outputs keep what is currently shown.
      m_lock = 1'b0;
      m_cnt8 = '0;
      m_cnt2 = '0;
      m_bin  = last_obs.bin;
      m_dir  = last_obs.dir;
      q.delete();
      q.push_back(idle_entry());
      q.push_back(idle_entry());
    end else begin
      e.step = 1'b0;
      if (v) begin
        b = g2b(g);
        if (!m_lock) begin
          m_dir = 2'b11;
        end else begin
          d  = $countones(g ^ m_ref);
          up = m_bin + 4'd1;
          dn = m_bin - 4'd1;
          if (d == 0) m_dir = 2'b00;
          else if (d > 1) begin
            m_dir  = 2'b11;
            e.step = 1'b1;
            if (m_cnt8 != 8'hff) m_cnt8 = m_cnt8 + 8'd1;
            if (m_cnt2 != 2'b11) m_cnt2 = m_cnt2 + 2'd1;
          end
          else if (b == up) m_dir = 2'b01;
          else if (b == dn) m_dir = 2'b10;
          else m_dir = 2'b11;
        end
        m_ref  = g;
        m_bin  = b;
        m_lock = 1'b1;
      end
      e.vld  = v;
      e.bin  = m_bin;
      e.dir  = m_dir;
      e.cnt8 = m_cnt8;
      e.cnt2 = m_cnt2;
      e.lock = m_lock;
      q.push_back(e);
    end
  endtask

  // Assert reset at a falling edge; outputs must take reset values immediately.
  task automatic pulse_reset();
    @(negedge clk);
    rstn     = 1'b0;
    in_valid = 1'b0;
    clr      = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_bin_out",   32'(bin_out),   32'(0));
    check("rst_dir",       32'(dir),       32'(3));
    check("rst_step_err",  32'(step_err),  32'(0));
    check("rst_err_cnt",   32'(err_cnt),   32'(0));
    check("rst_locked",    32'(locked),    32'(0));
    check("rst_sat_cnt",   32'(s_err_cnt), 32'(0));
    m_lock = 1'b0;
    m_ref  = '0;
    m_bin  = '0;
    m_dir  = 2'b11;
    m_cnt8 = '0;
    m_cnt2 = '0;
    q.delete();
    q.push_back(idle_entry());
    q.push_back(idle_entry());
    last_obs = idle_entry();
  endtask

  logic [3:0] cur_b;
  logic [3:0] cur_g;
  logic [3:0] jump_pat [8] = '{4'b0011, 4'b0101, 4'b0110, 4'b1001,
                               4'b1010, 4'b1100, 4'b0111, 4'b1111};

  initial begin
    int r;
    pulse_reset();

    // Counting up from zero
    cycle(1'b1, 4'b0000, 1'b0);
    cycle(1'b1, 4'b0001, 1'b0);
    cycle(1'b1, 4'b0011, 1'b0);
    cycle(1'b1, 4'b0010, 1'b0);
    cycle(1'b0, 4'b0000, 1'b0);
    cycle(1'b0, 4'b0000, 1'b0);

    // Reset with two samples in flight
    cycle(1'b1, 4'b0110, 1'b0);
    cycle(1'b1, 4'b0111, 1'b0);
    pulse_reset();

    // Wrap-around both ways
    cycle(1'b1, 4'b1000, 1'b0);
    cycle(1'b1, 4'b0000, 1'b0);
    cycle(1'b1, 4'b1000, 1'b0);
    cycle(1'b1, 4'b0101, 1'b1);

    // Jumps, then clear while locked with err_cnt=2
    cycle(1'b1, 4'b0001, 1'b0);
    cycle(1'b1, 4'b0010, 1'b0);
    cycle(1'b1, 4'b0101, 1'b0);
    cycle(1'b0, 4'b0000, 1'b0);
    cycle(1'b1, 4'b0110, 1'b1);
    cycle(1'b1, 4'b0100, 1'b0);

    // Five consecutive illegal jumps for saturation
    cycle(1'b1, 4'b0111, 1'b0);
    cycle(1'b1, 4'b0100, 1'b0);
    cycle(1'b1, 4'b0111, 1'b0);
    cycle(1'b1, 4'b0100, 1'b0);
    cycle(1'b1, 4'b0111, 1'b0);

    // Random walk with holds, jumps, bubbles and clears
    cur_g = 4'b0111;
    for (int k = 0; k < 400; k++) begin
      r = int'($urandom_range(0, 99));
      if (r < 10) begin
        cycle(1'b0, 4'(($urandom)), 1'b0);
      end else if (r < 13) begin
        cycle(1'($urandom_range(0, 1)), cur_g, 1'b1);
      end else if (r < 20) begin
        cur_g = cur_g ^ jump_pat[$urandom_range(0, 7)];
        cycle(1'b1, cur_g, 1'b0);
      end else begin
        cur_b = g2b(cur_g) + 4'($urandom_range(0, 2)) - 4'd1;
        cur_g = cur_b ^ (cur_b >> 1);
        cycle(1'b1, cur_g, 1'b0);
      end
    end

    // Drain
    repeat (3) cycle(1'b0, 4'b0000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
